rs232_clk_gen: RTL and testbench
================================

Name: rs232_clk_gen

Overview:
Baud-rate timing generator for the RS232 link. It divides the system clock by an integer ratio and produces a one-cycle bit-rate enable strobe for the transmitter and receiver. It also produces a 16x oversampling strobe for receiver start-bit and mid-bit sampling. It is a pure clock-enable source: it never gates a clock, and all consumers run on the same clock.

Parameters:
- RS232_RATIO, default 10417 (100 MHz / 9600 bps): system-clock cycles per RS232 bit period.
  - Legal range is 16..2^24-1.
  - Outside that range, elaboration fails with an $error / fatal message.
- CNT_W, default $clog2(RS232_RATIO): width of the bit counter. Derived only; do not override.

Ports:
- clk, input, 1: system clock; all logic on rising edge.
- rst, input, 1: synchronous reset, active-high.
- clk_rs232_en, output, 1: bit-rate strobe, high for exactly one clk cycle per RS232_RATIO cycles.
- clk_rs232_x16_en, output, 1: oversampling strobe; exactly 16 single-cycle pulses per RS232_RATIO cycles.
- clk_rs232_mid_en, output, 1: mid-bit strobe. Present only with the optional feature.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clk, rst).
- Registered outputs: every output is a flop, with no combinational path from rst.
- Reset: while rst=1 at a rising edge:
  - bit counter <- 0, x16 accumulator <- 0;
  - all strobes <- 0 on that edge.
- Reset mid-operation: restarts all phases from zero; no partial pulse is ever emitted.
- Bit counter:
  - cnt counts 0..RS232_RATIO-1 and then wraps to 0.
  - clk_rs232_en is registered high on the edge where cnt transitions RS232_RATIO-1 -> 0.
- clk_rs232_en timing:
  - The first strobe is visible after the RS232_RATIO-th rising edge following the last edge with rst=1.
  - Subsequent strobes are exactly RS232_RATIO cycles apart.
  - Duty is 1/RS232_RATIO; the strobe is never two cycles wide.
- x16 strobe: a phase accumulator acc, width CNT_W+1, updated each cycle with nxt = acc + 16.
  - If nxt >= RS232_RATIO: acc <- nxt - RS232_RATIO, clk_rs232_x16_en <- 1.
  - Otherwise: acc <- nxt, clk_rs232_x16_en <- 0.
  - Result: exactly 16 pulses per bit period, with a spacing jitter of at most 1 cycle.
  - acc returns to 0 on the same edge clk_rs232_en fires, so the 16th x16 pulse coincides with clk_rs232_en.
- Arithmetic: unsigned only. No overflow, because acc+16 < 2*RS232_RATIO.
- No enable or clear input: the generator free-runs whenever rst=0.

Optional Feature:
- Macro: RS232_CLK_GEN_MID_EN.
- Defined:
  - Port clk_rs232_mid_en exists.
  - It is registered high for one cycle on the edge where cnt transitions (RS232_RATIO/2)-1 -> RS232_RATIO/2, using integer division.
  - That places it half a bit period (floor) after each clk_rs232_en.
  - It is 0 in reset.
  - First pulse: RS232_RATIO/2 edges after reset release.
- Undefined:
  - The port and its logic are absent.
  - All other behaviour is identical.

Test Plan:
- RS232_RATIO=10417, 10 ns clk. Hold rst=1 for 2 edges, then release and run 500 us.
  - Expect clk_rs232_en pulses at edges 10417, 20834, 31251 and 41668 after release: 4 pulses, each 1 cycle wide.
  - Strobes stay 0 while rst=1.
- RS232_RATIO=20. Count clk_rs232_x16_en pulses over 200 cycles after release.
  - Expect exactly 160 pulses.
  - Expect the first pulse 2 edges after release.
  - Every clk_rs232_en coincides with an x16 pulse.
- RS232_RATIO=20. Assert rst for 1 cycle when cnt=13, then release.
  - Expect no strobe during reset.
  - Expect the next clk_rs232_en exactly 20 edges after release; x16 pattern restarts.
- RS232_RATIO=16, boundary case. Expect clk_rs232_x16_en high every cycle and clk_rs232_en every 16th cycle.
- With RS232_CLK_GEN_MID_EN defined and RS232_RATIO=21:
  - Expect clk_rs232_mid_en 10 edges after release, then every 21 cycles, always 11 cycles before each clk_rs232_en.
- RS232_RATIO=8: elaboration must fail with an error.

Source files
------------

// File: rtl/rs232_clk_gen.sv
// Baud-rate clock-enable generator: bit-rate strobe plus 16x oversampling strobe.
// Optional mid-bit strobe is compiled in when RS232_CLK_GEN_MID_EN is defined.
`timescale 1ns/1ps

module rs232_clk_gen #(
    parameter int RS232_RATIO = 10417,
    parameter int CNT_W       = $clog2(RS232_RATIO)
) (
    input  logic clk,
    input  logic rst,
    output logic clk_rs232_en,
`ifdef RS232_CLK_GEN_MID_EN
    output logic clk_rs232_mid_en,
`endif
    output logic clk_rs232_x16_en
);

    // Refuse to build with a ratio the 16x accumulator cannot serve.
    if ((RS232_RATIO < 16) || (RS232_RATIO > 32'h00FF_FFFF)) begin : g_ratioCheck
        $error("rs232_clk_gen: RS232_RATIO=%0d outside legal range 16..16777215", RS232_RATIO);
    end
    if (CNT_W != $clog2(RS232_RATIO)) begin : g_widthCheck
        $error("rs232_clk_gen: CNT_W must equal $clog2(RS232_RATIO)");
    end

    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(RS232_RATIO - 1);
    localparam logic [CNT_W:0]   LP_RATIO    = (CNT_W + 1)'(RS232_RATIO);
    localparam logic [CNT_W:0]   LP_STEP     = (CNT_W + 1)'(16);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W:0]   r_acc;
    logic             r_bitEn;
    logic             r_x16En;
    logic [CNT_W:0]   w_accNext;
    logic             w_cntWrap;

    // acc stays below RATIO, so acc+16 never reaches 2*RATIO and fits CNT_W+1 bits.
    assign w_accNext = r_acc + LP_STEP;
    assign w_cntWrap = (r_cnt == LP_CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_acc   <= '0;
            r_bitEn <= 1'b0;
            r_x16En <= 1'b0;
        end else begin
            r_cnt   <= w_cntWrap ? '0 : r_cnt + CNT_W'(1);
            r_bitEn <= w_cntWrap;
            if (w_accNext >= LP_RATIO) begin
                r_acc   <= w_accNext - LP_RATIO;
                r_x16En <= 1'b1;
            end else begin
                r_acc   <= w_accNext;
                r_x16En <= 1'b0;
            end
        end
    end

    assign clk_rs232_en     = r_bitEn;
    assign clk_rs232_x16_en = r_x16En;

`ifdef RS232_CLK_GEN_MID_EN
    // Fires on the cnt (RATIO/2)-1 -> RATIO/2 edge, half a bit after the bit strobe.
    localparam logic [CNT_W-1:0] LP_CNT_MID_PRE = CNT_W'((RS232_RATIO / 2) - 1);

    logic r_midEn;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_midEn <= 1'b0;
        end else begin
            r_midEn <= (r_cnt == LP_CNT_MID_PRE);
        end
    end

    assign clk_rs232_mid_en = r_midEn;
`endif

endmodule

// File: tb/tb_rs232_clk_gen.sv
// Directed self-checking bench for rs232_clk_gen at ratios 10417, 20, 16 (and 21 with
// RS232_CLK_GEN_MID_EN defined).
`timescale 1ns/1ps

module tb_rs232_clk_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstA, rstB, rstC;
    logic enA, x16A, enB, x16B, enC, x16C;
`ifdef RS232_CLK_GEN_MID_EN
    logic rstD, enD, x16D;
    logic midA, midB, midC, midD;
`endif

    int checkCount = 0;
    int failCount  = 0;

    rs232_clk_gen #(.RS232_RATIO(10417)) dutA (
        .clk(clk), .rst(rstA), .clk_rs232_en(enA),
`ifdef RS232_CLK_GEN_MID_EN
        .clk_rs232_mid_en(midA),
`endif
        .clk_rs232_x16_en(x16A));

    rs232_clk_gen #(.RS232_RATIO(20)) dutB (
        .clk(clk), .rst(rstB), .clk_rs232_en(enB),
`ifdef RS232_CLK_GEN_MID_EN
        .clk_rs232_mid_en(midB),
`endif
        .clk_rs232_x16_en(x16B));

    rs232_clk_gen #(.RS232_RATIO(16)) dutC (
        .clk(clk), .rst(rstC), .clk_rs232_en(enC),
`ifdef RS232_CLK_GEN_MID_EN
        .clk_rs232_mid_en(midC),
`endif
        .clk_rs232_x16_en(x16C));

`ifdef RS232_CLK_GEN_MID_EN
    rs232_clk_gen #(.RS232_RATIO(21)) dutD (
        .clk(clk), .rst(rstD), .clk_rs232_en(enD),
        .clk_rs232_mid_en(midD),
        .clk_rs232_x16_en(x16D));
`endif

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Advance one rising edge and settle 1 ns past it before sampling.
    task automatic stepEdge();
        @(posedge clk);
        #1;
    endtask

    // Drives the reset of every instance to the same level.
    task automatic applyStimulus(input logic rstValue);
        rstA = rstValue;
        rstB = rstValue;
        rstC = rstValue;
`ifdef RS232_CLK_GEN_MID_EN
        rstD = rstValue;
`endif
    endtask

    initial begin
        int aPulseEdge[4];
        int aPulses = 0, aWide = 0, aX16 = 0;
        int bX16 = 0, bFirst = 0, bCoinBad = 0, bModelBad = 0, bEn = 0, bEnBad = 0;
        int cX16 = 0, cEn = 0, cEnBad = 0;
        int rFirstEn = 0, rFirstX16 = 0, rModelBad = 0;
        logic prevEnA = 1'b0;
        logic expX16;
`ifdef RS232_CLK_GEN_MID_EN
        int aMid = 0, aMidFirst = 0, dMidBad = 0, dEnBad = 0, dMid = 0;
`endif
        for (int i = 0; i < 4; i++) aPulseEdge[i] = 0;

        $display("[TB] reset hold for 2 edges");
        applyStimulus(1'b1);
        for (int i = 0; i < 2; i++) begin
            stepEdge();
            checkOutput("resetA_en",  enA,  0);
            checkOutput("resetA_x16", x16A, 0);
            checkOutput("resetB_en",  enB,  0);
            checkOutput("resetB_x16", x16B, 0);
            checkOutput("resetC_en",  enC,  0);
            checkOutput("resetC_x16", x16C, 0);
`ifdef RS232_CLK_GEN_MID_EN
            checkOutput("resetA_mid", midA, 0);
            checkOutput("resetD_mid", midD, 0);
`endif
        end
        applyStimulus(1'b0);

        $display("[TB] free run 50000 edges (500 us)");
        for (int n = 1; n <= 50000; n++) begin
            stepEdge();
            if (enA) begin
                if (aPulses < 4) aPulseEdge[aPulses] = n;
                aPulses++;
                if (prevEnA) aWide++;
            end
            prevEnA = enA;
            if (x16A) aX16++;

            if (n <= 200) begin
                expX16 = ((16 * n) / 20) != ((16 * (n - 1)) / 20);
                if (x16B !== expX16) bModelBad++;
                if (x16B) begin
                    bX16++;
                    if (bFirst == 0) bFirst = n;
                end
                if (enB && !x16B) bCoinBad++;
                if (enB) bEn++;
                if (enB !== ((n % 20) == 0)) bEnBad++;
            end

            if (n <= 64) begin
                if (x16C) cX16++;
                if (enC) cEn++;
                if (enC !== ((n % 16) == 0)) cEnBad++;
            end

`ifdef RS232_CLK_GEN_MID_EN
            if (midA) begin
                if (aMid == 0) aMidFirst = n;
                aMid++;
            end
            if (n <= 84) begin
                if (midD) dMid++;
                if (midD !== ((n % 21) == 10)) dMidBad++;
                if (enD !== ((n % 21) == 0)) dEnBad++;
            end
`endif
        end

        checkOutput("A_pulseCount", aPulses, 4);
        checkOutput("A_pulse1", aPulseEdge[0], 10417);
        checkOutput("A_pulse2", aPulseEdge[1], 20834);
        checkOutput("A_pulse3", aPulseEdge[2], 31251);
        checkOutput("A_pulse4", aPulseEdge[3], 41668);
        checkOutput("A_wideStrobe", aWide, 0);
        checkOutput("A_x16Count", aX16, 76);
        checkOutput("B_x16Count", bX16, 160);
        checkOutput("B_x16First", bFirst, 2);
        checkOutput("B_enWithoutX16", bCoinBad, 0);
        checkOutput("B_x16Pattern", bModelBad, 0);
        checkOutput("B_enCount", bEn, 10);
        checkOutput("B_enPattern", bEnBad, 0);
        checkOutput("C_x16Count", cX16, 64);
        checkOutput("C_enCount", cEn, 4);
        checkOutput("C_enPattern", cEnBad, 0);
`ifdef RS232_CLK_GEN_MID_EN
        checkOutput("A_midCount", aMid, 5);
        checkOutput("A_midFirst", aMidFirst, 5208);
        checkOutput("D_midCount", dMid, 4);
        checkOutput("D_midPattern", dMidBad, 0);
        checkOutput("D_enPattern", dEnBad, 0);
`endif

        // dutB sits at cnt=0 after 50000 edges; 13 more edges bring it to cnt=13.
        $display("[TB] mid-operation reset of ratio-20 instance at cnt=13");
        for (int i = 0; i < 13; i++) stepEdge();
        rstB = 1'b1;
        stepEdge();
        checkOutput("midRst_en",  enB,  0);
        checkOutput("midRst_x16", x16B, 0);
        rstB = 1'b0;
        for (int n = 1; n <= 100; n++) begin
            stepEdge();
            if (n <= 20) begin
                expX16 = ((16 * n) / 20) != ((16 * (n - 1)) / 20);
                if (x16B !== expX16) rModelBad++;
            end
            if (x16B && rFirstX16 == 0) rFirstX16 = n;
            if (enB) begin
                rFirstEn = n;
                break;
            end
        end
        checkOutput("midRst_firstEn", rFirstEn, 20);
        checkOutput("midRst_firstX16", rFirstX16, 2);
        checkOutput("midRst_x16Pattern", rModelBad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
